// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer that drives an external combinational
// 1-bit ALU slice LSB first, completes the carry chain the slice's half adder
// lacks, and returns a registered WIDTH-bit result with carry/done/err/flags.
// Latency: operands accepted at edge E0, bits captured at E1..E_WIDTH, done
// is high for the cycle after E_WIDTH. No backpressure: start is only
// sampled in IDLE, so a start while busy is dropped (no queuing, no err).
// Ports: clk, rst (async, active-high); request start/op_in/a_in/b_in;
// slice drive slice_a/slice_b/slice_ainv/slice_binv/slice_cinv/slice_op;
// slice return slice_s/slice_cout; status busy/done/err; outputs result,
// carry_out, zero, ovf.
// Macro ALU_SEQ_FLAGS_EN: when defined, zero and ovf are registered at DONE
// entry; when undefined both ports are tied to 0.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_ainv,
   output logic             slice_binv,
   output logic             slice_cinv,
   output logic [2:0]       slice_op,
   input  logic             slice_s,
   input  logic             slice_cout,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             ovf
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic [IW-1:0]    idx;
   logic             carry;

   logic             op_legal;
   logic             accept;
   logic             is_sub;
   logic             is_arith;
   logic             last_bit;
   logic             bit_res;
   logic             carry_nxt;
   logic [WIDTH-1:0] res_nxt;

   assign op_legal = (op_in <= OP_SUB);
   assign accept   = (state == S_IDLE) && start && op_legal;
   assign is_sub   = (op_reg == OP_SUB);
   assign is_arith = (op_reg == OP_ADD) || is_sub;
   assign last_bit = (idx == IW'(WIDTH - 1));

   // The slice only forms a_eff ^ b_eff and a_eff & b_eff; fold in the
   // running carry here to make a full adder. SUB starts with carry=1 so
   // a + ~b + 1 gives the two's-complement difference.
   assign bit_res   = is_arith ? (slice_s ^ carry) : slice_s;
   assign carry_nxt = slice_cout | (slice_s & carry);

   always_comb begin
      res_nxt      = result;
      res_nxt[idx] = bit_res;
   end

   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign slice_ainv = 1'b0;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_RUN;
         S_RUN:   if (last_bit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Slice drive: quiet (all zero, AND select) outside RUN
   // ---------------------------------------------------------------------
   always_comb begin
      slice_a    = 1'b0;
      slice_b    = 1'b0;
      slice_binv = 1'b0;
      slice_cinv = 1'b0;
      slice_op   = 3'b000;
      if (state == S_RUN) begin
         slice_a    = a_reg[idx];
         slice_b    = b_reg[idx];
         slice_binv = is_sub;
         slice_cinv = is_sub;
         case (op_reg)
            OP_AND:  slice_op = 3'b000;
            OP_OR:   slice_op = 3'b100;
            OP_XOR:  slice_op = 3'b010;
            OP_NOR:  slice_op = 3'b110;
            default: slice_op = 3'b001;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= 3'd0;
         idx       <= '0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= (state == S_IDLE) && start && !op_legal;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  op_reg    <= op_in;
                  idx       <= '0;
                  carry     <= (op_in == OP_SUB);
                  result    <= '0;
                  carry_out <= 1'b0;
               end
            end
            S_RUN: begin
               result <= res_nxt;
               // Logic ops keep carry at 0 so carry_out falls out as 0.
               carry  <= is_arith & carry_nxt;
               if (last_bit) begin
                  carry_out <= is_arith & carry_nxt;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q;
   logic ovf_q;
   logic a_msb;
   logic b_eff_msb;

   assign a_msb     = a_reg[WIDTH-1];
   assign b_eff_msb = b_reg[WIDTH-1] ^ is_sub;

   // On the last RUN edge bit_res is the result MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if ((state == S_RUN) && last_bit) begin
         zero_q <= (res_nxt == '0);
         ovf_q  <= is_arith && (a_msb == b_eff_msb) && (bit_res != a_msb);
      end
   end

   assign zero = zero_q;
   assign ovf  = ovf_q;
`else
   assign zero = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed + randomized bench for serial_alu_seq (WIDTH=8)
// with a behavioural 1-bit slice attached to the slice_* ports. Expected
// values come from plain-arithmetic reference functions.
module tb_serial_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op_in = 3'd0;
   logic [7:0] a_in = 8'd0;
   logic [7:0] b_in = 8'd0;
   logic       slice_a, slice_b, slice_ainv, slice_binv, slice_cinv;
   logic [2:0] slice_op;
   logic       slice_s, slice_cout;
   logic       busy, done, err, carry_out, zero, ovf;
   logic [7:0] result;

   int n_vec = 0;
   int n_mis = 0;
   logic [7:0] prev_res = 8'd0;

   always #5 clk = ~clk;

   serial_alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op_in(op_in),
      .a_in(a_in), .b_in(b_in),
      .slice_a(slice_a), .slice_b(slice_b), .slice_ainv(slice_ainv),
      .slice_binv(slice_binv), .slice_cinv(slice_cinv), .slice_op(slice_op),
      .slice_s(slice_s), .slice_cout(slice_cout),
      .busy(busy), .done(done), .err(err), .result(result),
      .carry_out(carry_out), .zero(zero), .ovf(ovf)
   );

   // Behavioural 1-bit slice: half adder plus logic functions.
   logic a_eff, b_eff;
   assign a_eff = slice_a ^ slice_ainv;
   assign b_eff = slice_b ^ slice_binv;
   assign slice_cout = a_eff & b_eff;
   always_comb begin
      case (slice_op)
         3'b000:  slice_s = a_eff & b_eff;
         3'b100:  slice_s = a_eff | b_eff;
         3'b010:  slice_s = a_eff ^ b_eff;
         3'b110:  slice_s = ~(a_eff | b_eff);
         3'b001:  slice_s = a_eff ^ b_eff;
         default: slice_s = 1'b0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_sel(input logic [2:0] op);
      case (op)
         3'd0:    return 3'b000;
         3'd1:    return 3'b100;
         3'd2:    return 3'b010;
         3'd3:    return 3'b110;
         default: return 3'b001;
      endcase
   endfunction

   task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic c, output logic z, output logic v);
      int sa, sb, s;
      sa = $signed(a);
      sb = $signed(b);
      s  = 0;
      c  = 1'b0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a | b);
         3'd4: begin r = a + b; c = (int'(a) + int'(b)) > 255; s = sa + sb; end
         default: begin r = a - b; c = (a >= b); s = sa - sb; end
      endcase
      v = (op >= 3'd4) && (s > 127 || s < -128);
      z = (r == 8'd0);
`ifndef ALU_SEQ_FLAGS_EN
      z = 1'b0;
      v = 1'b0;
`endif
   endtask

   // inj: RUN cycle k (1..8) in which a stray ADD start is presented.
   // rst_at: edge Ek after which reset is asserted (aborts the op).
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int inj, input int rst_at);
      logic [7:0] er;
      logic ec, ez, ev;
      model(op, a, b, er, ec, ez, ev);
      @(posedge clk); #1;
      start = 1'b1; op_in = op; a_in = a; b_in = b;
      @(posedge clk); #1;                      // E0
      start = 1'b0; a_in = ~a; b_in = 8'($urandom);
      for (int k = 1; k <= 8; k++) begin
         if (k == inj) begin
            start = 1'b1; op_in = 3'd4;
         end
         @(negedge clk);
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         chk("run_sa", slice_a, a[k-1]);
         chk("run_sb", slice_b, b[k-1]);
         chk("run_sel", slice_op, exp_sel(op));
         chk("run_binv", slice_binv, op == 3'd5);
         chk("run_cinv", slice_cinv, op == 3'd5);
         @(posedge clk); #1;                   // Ek
         start = 1'b0;
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_carry", carry_out, 0);
            chk("rst_sel", slice_op, 0);
            chk("rst_sa", slice_a, 0);
            @(negedge clk);
            rst = 1'b0;
            prev_res = 8'd0;
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            return;
         end
      end
      @(negedge clk);                          // DONE cycle
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("result", result, er);
      chk("carry_out", carry_out, ec);
      chk("zero", zero, ez);
      chk("ovf", ovf, ev);
      chk("done_sel", slice_op, 0);
      @(negedge clk);
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("result_hold", result, er);
      prev_res = er;
   endtask

   initial begin
      #2 rst = 1'b1;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_result", result, 0);
      chk("reset_carry", carry_out, 0);
      chk("reset_flags", {zero, ovf}, 0);
      chk("reset_slice", {slice_a, slice_b, slice_ainv, slice_binv, slice_cinv, slice_op}, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op(3'd4, 8'h7F, 8'h01, -1, -1);       // ADD overflow
      do_op(3'd5, 8'h05, 8'h05, -1, -1);       // SUB to zero
      do_op(3'd4, 8'hFF, 8'h01, -1, -1);       // ADD wrap with carry
      do_op(3'd3, 8'hF0, 8'h0F, -1, -1);       // NOR
      do_op(3'd2, 8'hA5, 8'h3C, 3, -1);        // XOR with stray start at E3
      @(negedge clk);
      chk("stray_start_idle", busy, 0);
      chk("stray_start_done", done, 0);

      // Illegal op in IDLE
      @(posedge clk); #1;
      start = 1'b1; op_in = 3'd6; a_in = 8'h12; b_in = 8'h34;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("illegal_err", err, 1);
      chk("illegal_busy", busy, 0);
      @(negedge clk);
      chk("illegal_err_clr", err, 0);
      chk("illegal_busy2", busy, 0);
      chk("illegal_done", done, 0);
      chk("illegal_result", result, prev_res);

      do_op(3'd4, 8'h33, 8'h44, -1, 4);        // reset mid-run
      do_op(3'd4, 8'h01, 8'h02, -1, -1);

      for (int i = 0; i < 24; i++) begin
         do_op(3'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
